// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage LSU: funct3 access codes, FSM states,
// and the store-side legality/formatting helpers used at launch time.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Stores share the low three load encodings, so LBU/LHU codes are legal only for loads.
    function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~off[0];
            F3_LW:   ok = (off == 2'b00);
            F3_LBU:  ok = is_load;
            F3_LHU:  ok = is_load & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_SB:   w = {4{d[7:0]}};
            F3_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << off;
            F3_SH:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: shifts the returned word down to the addressed lane
// and sign- or zero-extends according to funct3.
module lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h000000, shifted[7:0]};
            F3_LHU:  data = {16'h0000, shifted[15:0]};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: launches one data-memory access per instruction,
// formats store lanes, aligns load data and stalls the pipeline until completion.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        stall_o,
    output logic [1:0]  dbg_state
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    lsu_state_e           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           be_q;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic [31:0]          load_q;
    logic                 timeout_q;

    logic                 mem_op;
    logic                 legal;
    logic                 launch;
    logic                 illegal;
    logic [31:0]          aligned;

    // A load wins if both read and write are flagged.
    assign mem_op  = in_valid_i & (mem_read_i | mem_write_i);
    assign legal   = access_legal(mem_read_i, funct3_i, addr_i[1:0]);
    assign launch  = (state == LSU_IDLE) & mem_op & legal;
    assign illegal = (state == LSU_IDLE) & mem_op & ~legal;

    lsu_load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    // Handshake: the request is held with stable addr/wdata/be/we while dmem_req_o=1
    // and transfers on the cycle dmem_ready_i=1; read data is taken only on a later
    // cycle with dmem_rvalid_i=1, never in the handshake cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LSU_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            load_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (launch) begin
                        addr_q    <= {addr_i[31:2], 2'b00};
                        off_q     <= addr_i[1:0];
                        f3_q      <= funct3_i;
                        we_q      <= ~mem_read_i;
                        wdata_q   <= mem_read_i ? 32'h0000_0000 : store_wdata(funct3_i, store_data_i);
                        be_q      <= mem_read_i ? 4'b1111 : store_be(funct3_i, addr_i[1:0]);
                        timeout_q <= 1'b0;
                        state     <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (dmem_ready_i) begin
                        cnt   <= '0;
                        state <= we_q ? LSU_DONE : LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (dmem_rvalid_i) begin
                        load_q <= aligned;
                        state  <= LSU_DONE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (cnt == TIMEOUT_LAST) begin
                            load_q    <= '0;
                            timeout_q <= 1'b1;
                            state     <= LSU_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LSU_DONE: begin
                    timeout_q <= 1'b0;
                    state     <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    assign dmem_req_o   = (state == LSU_REQ);
    assign dmem_we_o    = (state == LSU_REQ) & we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign load_data_o  = load_q;
    assign done_o       = (state == LSU_DONE);
    assign fault_o      = illegal | ((state == LSU_DONE) & timeout_q);
    assign stall_o      = launch | (state == LSU_REQ) | (state == LSU_WAIT);
    assign dbg_state    = state;

endmodule
